// File: rtl/datapath_pkg.sv
// Shared definitions for the pixel datapath stages: widths, latency and
// the binomial kernel arithmetic used by the 3x3 Gaussian smoother.
package datapath_pkg;

  localparam int PIX_W          = 8;
  localparam int GAUSS3_LATENCY = 3;

  // Kernel [1 2 1] per axis: outer taps weight 1, middle tap weight 2.
  localparam int OUTER_SHIFT = 0;
  localparam int MID_SHIFT   = 1;
  // Total kernel weight is 16, so the final sum is normalised by >> 4.
  localparam int NORM_SHIFT  = 4;

  localparam int VSUM_W = 10;
  localparam int HSUM_W = 12;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [VSUM_W-1:0] vsum_t;
  typedef logic [HSUM_W-1:0] hsum_t;

  // Vertical 1-2-1 sum of three pixels; max 4*255 = 1020 fits in 10 bits.
  function automatic vsum_t weigh3_v(input pixel_t a, input pixel_t b, input pixel_t c);
    vsum_t ea, eb, ec;
    ea = vsum_t'(a) << OUTER_SHIFT;
    eb = vsum_t'(b) << MID_SHIFT;
    ec = vsum_t'(c) << OUTER_SHIFT;
    return ea + eb + ec;
  endfunction

  // Horizontal 1-2-1 sum of three vertical sums, normalised by 16 with
  // truncation; max 4080 >> 4 = 255 so the result never overflows a pixel.
  function automatic pixel_t weigh3_h_norm(input vsum_t a, input vsum_t b, input vsum_t c);
    hsum_t ea, eb, ec, sum;
    ea  = hsum_t'(a) << OUTER_SHIFT;
    eb  = hsum_t'(b) << MID_SHIFT;
    ec  = hsum_t'(c) << OUTER_SHIFT;
    sum = ea + eb + ec;
    return pixel_t'(sum >> NORM_SHIFT);
  endfunction

endpackage

// File: rtl/datapath_gauss3_linebuf.sv
// One image row of pixel storage. The read port is combinational, so the
// value seen on the write cycle is the old contents (read-before-write).
module datapath_gauss3_linebuf
  import datapath_pkg::*;
#(
  parameter int C_DEPTH = 8,
  localparam int AW = $clog2(C_DEPTH)
) (
  input  logic          i_clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  pixel_t        wr_data,
  output pixel_t        rd_data
);

  pixel_t mem [C_DEPTH];

  assign rd_data = mem[addr];

  // Write the new pixel into the current column slot when enabled.
  always_ff @(posedge i_clk) begin
    if (en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/datapath_gauss3.sv
// Streaming 3x3 Gaussian smoother ([1 2 1; 2 4 2; 1 2 1]/16) for an 8-bit
// gray pixel stream. Three-stage pipeline that freezes entirely on busy_in;
// outputs whose window runs off the top or left edge are forced to zero.
module datapath_gauss3
  import datapath_pkg::*;
#(
  parameter int C_ROW_SIZE = 8
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  pixel_t data_in,
  input  logic   valid_in,
  input  logic   sof_in,
  output logic   busy_out,
  output pixel_t data_out,
  output logic   valid_out,
  output logic   sof_out,
  input  logic   busy_in
);

  localparam int COL_W = $clog2(C_ROW_SIZE);

  logic             advance;
  logic             accept;
  logic [COL_W-1:0] col_cnt, col_eff, col_next;
  logic [1:0]       row_cnt, row_eff, row_next;
  logic             win_incomplete;

  pixel_t mid_rd, top_rd;

  logic   s1_valid, s1_sof, s1_mask;
  pixel_t s1_pix, s1_top, s1_mid;

  logic   s2_valid, s2_sof, s2_mask;
  vsum_t  vsum, v0, v1, v2;
  pixel_t h_norm;

  assign busy_out = busy_in;
  assign advance  = ~busy_in;
  assign accept   = valid_in & ~busy_in;

  // Position of the incoming pixel (sof forces 0,0) and the following position.
  always_comb begin
    col_eff  = sof_in ? '0 : col_cnt;
    row_eff  = sof_in ? '0 : row_cnt;
    col_next = col_eff + COL_W'(1);
    row_next = row_eff;
    if (col_eff == COL_W'(C_ROW_SIZE - 1)) begin
      col_next = '0;
      if (row_eff != 2'd2) row_next = row_eff + 2'd1;
    end
    win_incomplete = (row_eff < 2'd2) || (col_eff < COL_W'(2));
  end

  // Row 0 buffer holds the previous row, row 1 buffer the one before that.
  datapath_gauss3_linebuf #(.C_DEPTH(C_ROW_SIZE)) u_lb0 (
    .i_clk   (i_clk),
    .en      (accept),
    .addr    (col_eff),
    .wr_data (data_in),
    .rd_data (mid_rd)
  );

  datapath_gauss3_linebuf #(.C_DEPTH(C_ROW_SIZE)) u_lb1 (
    .i_clk   (i_clk),
    .en      (accept),
    .addr    (col_eff),
    .wr_data (mid_rd),
    .rd_data (top_rd)
  );

  // Column/row position tracking; row saturates at 2 since only "<2" matters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      col_cnt <= col_next;
      row_cnt <= row_next;
    end
  end

  // Stage 1 control: valid/sof qualifiers, bubbles pass when not stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
    end else if (advance) begin
      s1_valid <= valid_in;
      s1_sof   <= valid_in & sof_in;
    end
  end

  // Stage 1 data: the three vertical taps and the border mask for this pixel.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_pix  <= data_in;
      s1_top  <= top_rd;
      s1_mid  <= mid_rd;
      s1_mask <= win_incomplete;
    end
  end

  assign vsum = weigh3_v(s1_top, s1_mid, s1_pix);

  // Stage 2 control: pass valid/sof down the pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
    end
  end

  // Stage 2 data: horizontal window of vertical sums, shifted only by real pixels.
  always_ff @(posedge i_clk) begin
    if (advance && s1_valid) begin
      s2_mask <= s1_mask;
      v0      <= vsum;
      v1      <= v0;
      v2      <= v1;
    end
  end

  assign h_norm = weigh3_h_norm(v2, v1, v0);

  // Stage 3: apply the border mask and register the result.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end else if (advance) begin
      valid_out <= s2_valid;
      sof_out   <= s2_sof;
      data_out  <= (s2_valid && !s2_mask) ? h_norm : '0;
    end
  end

endmodule
